serial_tx_arbiter: RTL and testbench
====================================

SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, serial byte width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, TX FIFO entries; power of two, minimum 2.
REQ-003 The block SHALL have port clock  input  1  rising-edge clock for all state.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port req0_data  input  DATA_W  requester 0 byte (processor store path).
REQ-006 The block SHALL have port req0_valid  input  1  requester 0 has a byte.
REQ-007 The block SHALL have port req0_ready  output  1  requester 0 byte accepted this cycle when high with req0_valid.
REQ-008 The block SHALL have ports req1_data, req1_valid, req1_ready with the same widths, directions and meanings for requester 1 (debug monitor).
REQ-009 The block SHALL have port serial_ready_in  input  1  serial port can take a byte.
REQ-010 The block SHALL have port serial_out  output  DATA_W  byte to serial port.
REQ-011 The block SHALL have port serial_wren_out  output  1  one-cycle write strobe for serial_out.
REQ-012 The block SHALL have port fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 The block SHALL have port busy  output  1  high when fifo_count nonzero or serial_wren_out high.

Function
REQ-014 Per cycle the block SHALL accept at most one byte total from both requesters.
REQ-015 Grant SHALL be combinational from valids, the round-robin pointer and fifo_count; reqN_ready SHALL be high only for the granted requester and only when fifo_count < FIFO_DEPTH (pre-pop count; no same-cycle full-bypass).
REQ-016 Round-robin: one valid -> that requester granted; both valid -> requester other than last_served granted; last_served SHALL update only on an accepted byte.
REQ-017 An accepted byte SHALL be written at the FIFO tail on that rising edge; write pointer SHALL wrap from FIFO_DEPTH-1 to 0.
REQ-018 On each rising edge with fifo_count > 0 (pre-edge) and serial_ready_in high, the block SHALL register the head byte into serial_out, set serial_wren_out=1 and advance the read pointer (wrapping); otherwise serial_wren_out SHALL be 0 and serial_out SHALL hold its value.
REQ-019 Latency: byte accepted at edge N SHALL appear with serial_wren_out at edge N+1 at earliest (no empty-FIFO bypass).
REQ-020 Simultaneous push and pop SHALL leave fifo_count unchanged; push-only +1, pop-only -1.
REQ-021 Bytes SHALL leave in acceptance order; no byte SHALL be dropped or duplicated.
REQ-022 serial_ready_in low SHALL stall output indefinitely with FIFO contents preserved.
REQ-023 reqN_ready SHALL be 0 whenever reqN_valid is 0.

Reset
REQ-024 While reset is high at a rising edge: pointers=0, fifo_count=0, serial_wren_out=0, serial_out=0, last_served=1 (req0 wins first tie).
REQ-025 Reset mid-transfer SHALL discard all FIFO contents; req0_ready and req1_ready SHALL be 0 while reset is high.

Configuration
REQ-026 With macro SERIAL_TX_ARBITER_FIXED_PRIO_EN defined, tie-break SHALL be fixed priority, req0 always over req1, last_served unused.
REQ-027 Without SERIAL_TX_ARBITER_FIXED_PRIO_EN, round-robin per REQ-016 SHALL apply.

Verification
REQ-028 Reset, req0 sends 0x48 once, serial_ready_in=1 -> serial_wren_out high exactly one cycle, edge after acceptance, serial_out=0x48, busy then 0.
REQ-029 Both requesters valid continuously (req0=0x41, req1=0x42), ready=1, round-robin -> output sequence 0x41,0x42,0x41,0x42; with FIXED_PRIO_EN -> 0x41 repeated, req1_ready never high.
REQ-030 serial_ready_in=0, req0 pushes 0x30..0x35 -> four accepted, fifo_count=4, req0_ready low; raise ready -> 0x30,0x31,0x32,0x33 out on consecutive cycles, then 0x34,0x35 accepted.
REQ-031 Sustained push and pop with ready=1 through ≥3 pointer wraps -> fifo_count stays 1, output equals input order.
REQ-032 fifo_count=3, assert reset one cycle -> fifo_count=0, serial_wren_out=0 next cycle, no stale bytes emitted after release.

Source files
------------

// File: rtl/serial_tx_arbiter.sv
// Two-requester serial transmit arbiter: round-robin grant into a small TX FIFO drained to a serial port.
// Define SERIAL_TX_ARBITER_FIXED_PRIO_EN to make requester 0 always win a tie.
module serial_tx_arbiter #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [DATA_W-1:0]             req0_data,
   input  logic                          req0_valid,
   output logic                          req0_ready,
   input  logic [DATA_W-1:0]             req1_data,
   input  logic                          req1_valid,
   output logic                          req1_ready,
   input  logic                          serial_ready_in,
   output logic [DATA_W-1:0]             serial_out,
   output logic                          serial_wren_out,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
   localparam logic [AW-1:0] LAST_PTR_C = AW'(FIFO_DEPTH - 1);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              wren_q, wren_d;

   logic              pick0, pick1;
   logic              not_full;
   logic              push, pop;
   logic [DATA_W-1:0] push_data;

`ifdef SERIAL_TX_ARBITER_FIXED_PRIO_EN
   always_comb begin
      pick0 = req0_valid;
      pick1 = req1_valid & ~req0_valid;
   end
`else
   // last_served_q names the requester that won the most recent accepted byte.
   logic last_served_q, last_served_d;

   always_comb begin
      pick0 = req0_valid & (~req1_valid |  last_served_q);
      pick1 = req1_valid & (~req0_valid | ~last_served_q);
   end

   always_comb begin
      last_served_d = last_served_q;
      if (req0_ready) begin
         last_served_d = 1'b0;
      end else if (req1_ready) begin
         last_served_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         last_served_q <= 1'b1;
      end else begin
         last_served_q <= last_served_d;
      end
   end
`endif

   // Full is judged on the pre-pop count, so a full FIFO never accepts even while draining.
   always_comb begin
      not_full   = (count_q < DEPTH_C);
      req0_ready = pick0 & not_full & ~reset;
      req1_ready = pick1 & not_full & ~reset;
      push       = req0_ready | req1_ready;
      push_data  = req0_ready ? req0_data : req1_data;
      pop        = (count_q != '0) & serial_ready_in;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      out_d    = out_q;
      wren_d   = 1'b0;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR_C) ? '0 : wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR_C) ? '0 : rd_ptr_q + AW'(1);
         out_d    = mem_q[rd_ptr_q];
         wren_d   = 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         out_q    <= '0;
         wren_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         out_q    <= out_d;
         wren_q   <= wren_d;
      end
   end

   // Storage is not reset; clearing the pointers and count is enough to discard contents.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   always_comb begin
      serial_out      = out_q;
      serial_wren_out = wren_q;
      fifo_count      = count_q;
      busy            = (count_q != '0) | wren_q;
   end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter: queue-based reference model predicts grants and output order.
module tb_serial_tx_arbiter;

   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 4;

   logic                        clock = 1'b0;
   logic                        reset = 1'b1;
   logic [DATA_W-1:0]           req0_data = '0;
   logic                        req0_valid = 1'b0;
   logic                        req0_ready;
   logic [DATA_W-1:0]           req1_data = '0;
   logic                        req1_valid = 1'b0;
   logic                        req1_ready;
   logic                        serial_ready_in = 1'b0;
   logic [DATA_W-1:0]           serial_out;
   logic                        serial_wren_out;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                        busy;

   serial_tx_arbiter #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clock          (clock),
      .reset          (reset),
      .req0_data      (req0_data),
      .req0_valid     (req0_valid),
      .req0_ready     (req0_ready),
      .req1_data      (req1_data),
      .req1_valid     (req1_valid),
      .req1_ready     (req1_ready),
      .serial_ready_in(serial_ready_in),
      .serial_out     (serial_out),
      .serial_wren_out(serial_wren_out),
      .fifo_count     (fifo_count),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   // Reference model: queue of stored bytes, last winner, and whether a strobe is due.
   logic [DATA_W-1:0] mq [$];
   logic [DATA_W-1:0] sb [$];
   bit                m_last = 1'b1;
   bit                m_wren = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   task automatic cycle(input bit v0, input logic [DATA_W-1:0] d0,
                        input bit v1, input logic [DATA_W-1:0] d1,
                        input bit rdy, input bit rst, output bit acc0);
      bit e0, e1, full;
      @(negedge clock);
      req0_valid      = v0;
      req0_data       = d0;
      req1_valid      = v1;
      req1_data       = d1;
      serial_ready_in = rdy;
      reset           = rst;
      #1;
      full = (mq.size() >= FIFO_DEPTH);
      if (rst) begin
         e0 = 0; e1 = 0;
      end else if (v0 && v1) begin
`ifdef SERIAL_TX_ARBITER_FIXED_PRIO_EN
         e0 = 1;
`else
         e0 = (m_last == 1'b1);
`endif
         e1 = !e0;
      end else begin
         e0 = v0; e1 = v1;
      end
      e0 = e0 && !full;
      e1 = e1 && !full;
      chk("req0_ready", int'(req0_ready), int'(e0));
      chk("req1_ready", int'(req1_ready), int'(e1));
      chk("fifo_count", int'(fifo_count), mq.size());
      chk("busy", int'(busy), int'(mq.size() != 0 || m_wren));
      acc0 = e0;
      @(posedge clock);
      if (rst) begin
         mq.delete();
         m_last = 1'b1;
         m_wren = 1'b0;
      end else begin
         m_wren = (mq.size() > 0) && rdy;
         if (m_wren) sb.push_back(mq.pop_front());
         if (e0) begin mq.push_back(d0); m_last = 1'b0; end
         if (e1) begin mq.push_back(d1); m_last = 1'b1; end
      end
   endtask

   // Monitor: every strobe must match the oldest byte the model has released.
   initial begin
      logic [DATA_W-1:0] exp;
      forever begin
         @(negedge clock);
         if (mon_en && serial_wren_out) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_wren: serial_out 0x%0h with no byte due at %0t", serial_out, $time);
            end else begin
               exp = sb.pop_front();
               chk("serial_out", int'(serial_out), int'(exp));
            end
         end
      end
   end

   initial begin
      bit a;
      int k;
      int guard;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_count", int'(fifo_count), 0);
      chk("rst_wren", int'(serial_wren_out), 0);
      chk("rst_out", int'(serial_out), 0);
      chk("rst_ready0", int'(req0_ready), 0);
      mon_en = 1'b1;

      // Single byte through an idle block.
      cycle(1, 8'h48, 0, 8'h00, 1, 0, a);
      repeat (3) cycle(0, 8'h00, 0, 8'h00, 1, 0, a);

      // Both requesters contending continuously.
      repeat (4) cycle(1, 8'h41, 1, 8'h42, 1, 0, a);
      repeat (3) cycle(0, 8'h00, 0, 8'h00, 1, 0, a);

      // Stall, fill, then release.
      k = 0; guard = 0;
      while (k < 6 && guard < 40) begin
         cycle(1, DATA_W'(8'h30 + k), 0, 8'h00, (guard >= 6), 0, a);
         if (a) k++;
         guard++;
      end
      chk("stall_fill_done", k, 6);
      repeat (4) cycle(0, 8'h00, 0, 8'h00, 1, 0, a);

      // Sustained push and pop through several pointer wraps.
      for (int i = 0; i < 16; i++) cycle(1, DATA_W'(8'h80 + i), 0, 8'h00, 1, 0, a);
      repeat (3) cycle(0, 8'h00, 0, 8'h00, 1, 0, a);

      // Reset with three bytes held.
      for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, DATA_W'(8'hA0 + i), 0, 0, a);
      cycle(1, 8'h55, 1, 8'h66, 1, 1, a);
      repeat (4) cycle(0, 8'h00, 0, 8'h00, 1, 0, a);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 1), DATA_W'($urandom), $urandom_range(0, 1), DATA_W'($urandom),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0), a);
      end

      guard = 0;
      while ((mq.size() != 0 || m_wren) && guard < 20) begin
         cycle(0, 8'h00, 0, 8'h00, 1, 0, a);
         guard++;
      end
      repeat (2) cycle(0, 8'h00, 0, 8'h00, 1, 0, a);
      chk("drain_model_empty", mq.size(), 0);
      chk("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
